// File: rtl/ddr_setup_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_setup_pkg
//  Purpose  : Shared types for the DDR region initialiser: sequencer state
//             encoding, fill-pattern mode encoding and the per-lane pattern
//             function used by the pattern generator.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ddr_setup_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_CAL  = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_CMD  = 3'd3,
      ST_READ_DATA = 3'd4,
      ST_DONE      = 3'd5,
      ST_FAIL      = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      PAT_ZERO      = 2'd0,
      PAT_INDEX     = 2'd1,
      PAT_CONST     = 2'd2,
      PAT_INV_INDEX = 2'd3
   } pat_mode_t;

   localparam int LANE_W = 32;

   // Value of one 32-bit lane of word 'idx' for the selected fill mode.
   function automatic logic [LANE_W-1:0] lane_value(input pat_mode_t       m,
                                                    input logic [LANE_W-1:0] idx,
                                                    input logic [LANE_W-1:0] cpat);
      logic [LANE_W-1:0] v;
      case (m)
         PAT_ZERO:  v = '0;
         PAT_INDEX: v = idx;
         PAT_CONST: v = cpat;
         default:   v = ~idx;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_pattern_gen
//  Purpose  : Produces the expected memory word for word index i under the
//             selected fill mode. Every 32-bit lane carries the same value.
//             Shared by the write path and the read-back comparator.
//  Ports    : mode - fill pattern select (pat_mode_t encoding)
//             i    - word index within the region
//             word - DATA_W-bit pattern word
//  Revision : 1.0  initial release
// ============================================================================
module ddr_pattern_gen
   import ddr_setup_pkg::*;
#(
   parameter int          DATA_W    = 256,
   parameter int          IDX_W     = 10,
   parameter logic [31:0] CONST_PAT = 32'hA5A5_5A5A
) (
   input  logic [1:0]        mode,
   input  logic [IDX_W-1:0]  i,
   output logic [DATA_W-1:0] word
);

   localparam int LANES = DATA_W / LANE_W;

   logic [LANE_W-1:0] lane;

   always_comb begin
      lane = lane_value(pat_mode_t'(mode), LANE_W'(i), CONST_PAT);
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign word[g*LANE_W +: LANE_W] = lane;
   end

endmodule
`default_nettype wire

// File: rtl/ddr_region_init.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_region_init
//  Purpose  : After DDR calibration, fills a region of memory with a
//             selectable pattern over an Avalon-MM burst master, optionally
//             reads the region back and counts mismatching words.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             start, mode           - start pulse and pattern select
//             local_cal_success/fail- DDR calibration status
//             amm_*                 - Avalon-MM burst master
//             busy                  - sequence in progress
//             setup_done            - sticky, region initialised (verified)
//             setup_error           - sticky, mismatch or calibration fail
//             err_count             - saturating mismatch count
//  Revision : 1.0  initial release
// ============================================================================
module ddr_region_init
   import ddr_setup_pkg::*;
#(
   parameter int          ADDR_W     = 25,
   parameter int          DATA_W     = 256,
   parameter int          BURST_LEN  = 64,
   parameter int          NUM_WORDS  = 1024,
   parameter int          BASE_ADDR  = 0,
   parameter logic [31:0] CONST_PAT  = 32'hA5A5_5A5A,
   parameter int          VERIFY     = 1,
   parameter int          AUTO_START = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic                         local_cal_success,
   input  logic                         local_cal_fail,
   output logic [ADDR_W-1:0]            amm_addr,
   output logic [DATA_W-1:0]            amm_writedata,
   input  logic [DATA_W-1:0]            amm_readdata,
   output logic                         amm_read,
   output logic                         amm_write,
   output logic [DATA_W/8-1:0]          amm_byteenable,
   output logic [$clog2(BURST_LEN):0]   amm_burstcount,
   input  logic                         amm_readdatavalid,
   input  logic                         amm_ready,
   output logic                         busy,
   output logic                         setup_done,
   output logic                         setup_error,
   output logic [15:0]                  err_count
);

   localparam int BURST_W = $clog2(BURST_LEN) + 1;
   localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   state_t              state;
   state_t              next_state;
   logic [IDX_W-1:0]    word_idx;
   logic [BURST_W-1:0]  beat;
   logic [ADDR_W-1:0]   burst_addr;
   logic [1:0]          mode_q;
   logic                auto_pending;

   logic [DATA_W-1:0]   exp_word;
   logic                wr_accept;
   logic                rd_beat;
   logic                beat_last;
   logic                word_last;
   logic                mismatch;
   logic                enter_wait;
   logic                enter_done;
   logic                enter_fail;
   logic [15:0]         err_next;

   // One generator serves both directions: writes and compares never overlap.
   ddr_pattern_gen #(
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W),
      .CONST_PAT (CONST_PAT)
   ) u_pattern (
      .mode (mode_q),
      .i    (word_idx),
      .word (exp_word)
   );

   // A calibration loss aborts the cycle it is seen in, so no beat is counted.
   assign wr_accept = (state == ST_WRITE) && amm_ready && !local_cal_fail;
   assign rd_beat   = (state == ST_READ_DATA) && amm_readdatavalid && !local_cal_fail;
   assign beat_last = (beat == BURST_W'(BURST_LEN - 1));
   assign word_last = (word_idx == IDX_W'(NUM_WORDS - 1));
   assign mismatch  = rd_beat && (amm_readdata != exp_word);
   assign err_next  = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;

   assign enter_wait = (next_state == ST_WAIT_CAL) && (state != ST_WAIT_CAL);
   assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);
   assign enter_fail = (next_state == ST_FAIL) && (state != ST_FAIL);

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (start || auto_pending) next_state = ST_WAIT_CAL;
         end
         ST_WAIT_CAL: begin
            if (local_cal_fail)         next_state = ST_FAIL;
            else if (local_cal_success) next_state = ST_WRITE;
         end
         ST_WRITE: begin
            if (local_cal_fail) begin
               next_state = ST_FAIL;
            end else if (wr_accept && beat_last && word_last) begin
               next_state = (VERIFY != 0) ? ST_READ_CMD : ST_DONE;
            end
         end
         ST_READ_CMD: begin
            if (local_cal_fail)  next_state = ST_FAIL;
            else if (amm_ready)  next_state = ST_READ_DATA;
         end
         ST_READ_DATA: begin
            if (local_cal_fail) begin
               next_state = ST_FAIL;
            end else if (rd_beat && beat_last) begin
               next_state = word_last ? ST_DONE : ST_READ_CMD;
            end
         end
         ST_DONE, ST_FAIL: begin
            if (start) next_state = ST_WAIT_CAL;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      amm_write     = 1'b0;
      amm_read      = 1'b0;
      amm_addr      = '0;
      amm_writedata = '0;
      busy          = 1'b0;
      case (state)
         ST_WAIT_CAL: begin
            busy = 1'b1;
         end
         ST_WRITE: begin
            busy          = 1'b1;
            amm_write     = 1'b1;
            amm_addr      = burst_addr;
            amm_writedata = exp_word;
         end
         ST_READ_CMD: begin
            busy     = 1'b1;
            amm_read = 1'b1;
            amm_addr = burst_addr;
         end
         ST_READ_DATA: begin
            busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign amm_byteenable = '1;
   assign amm_burstcount = BURST_W'(BURST_LEN);

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         word_idx     <= '0;
         beat         <= '0;
         burst_addr   <= ADDR_W'(BASE_ADDR);
         mode_q       <= 2'd0;
         auto_pending <= (AUTO_START != 0);
         setup_done   <= 1'b0;
         setup_error  <= 1'b0;
         err_count    <= '0;
      end else begin
         if (enter_wait) begin
            // The automatic start after reset always fills with zeros.
            mode_q       <= start ? mode : 2'd0;
            auto_pending <= 1'b0;
            word_idx     <= '0;
            beat         <= '0;
            burst_addr   <= ADDR_W'(BASE_ADDR);
            setup_done   <= 1'b0;
            setup_error  <= 1'b0;
            err_count    <= '0;
         end

         if (wr_accept || rd_beat) begin
            if (beat_last) begin
               beat <= '0;
               if (word_last) begin
                  word_idx   <= '0;
                  burst_addr <= ADDR_W'(BASE_ADDR);
               end else begin
                  word_idx   <= word_idx + 1'b1;
                  burst_addr <= burst_addr + ADDR_W'(BURST_LEN);
               end
            end else begin
               beat     <= beat + 1'b1;
               word_idx <= word_idx + 1'b1;
            end
         end

         if (rd_beat) err_count <= err_next;

         // err_next folds in a mismatch on the very last read beat.
         if (enter_done) begin
            setup_done  <= 1'b1;
            setup_error <= setup_error | (err_next != 16'd0);
         end

         if (enter_fail) setup_error <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ddr_region_init.sv
`timescale 1ns/1ps
`default_nettype none
module tb_ddr_region_init;

   localparam int          AW   = 25;
   localparam int          DW   = 64;
   localparam int          BL   = 4;
   localparam int          NW   = 8;
   localparam logic [31:0] CPAT = 32'hA5A5_5A5A;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main DUT (VERIFY=1, AUTO_START=1)
   logic          reset, start, cal_ok, cal_fail, rdv, ready;
   logic [1:0]    mode;
   logic [AW-1:0] amm_addr;
   logic [DW-1:0] wdata, rdata;
   logic          rd, wr, busy, done, err;
   logic [7:0]    be;
   logic [2:0]    bc;
   logic [15:0]   errcnt;

   // write-only DUT (VERIFY=0, AUTO_START=0)
   logic          nv_reset, nv_start, nv_cal_ok, nv_cal_fail, nv_rdv, nv_ready;
   logic [1:0]    nv_mode;
   logic [AW-1:0] nv_addr;
   logic [DW-1:0] nv_wdata, nv_rdata;
   logic          nv_rd, nv_wr, nv_busy, nv_done, nv_err;
   logic [7:0]    nv_be;
   logic [2:0]    nv_bc;
   logic [15:0]   nv_errcnt;

   ddr_region_init #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .NUM_WORDS(NW), .BASE_ADDR(0),
      .CONST_PAT(CPAT), .VERIFY(1), .AUTO_START(1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .local_cal_success(cal_ok), .local_cal_fail(cal_fail),
      .amm_addr(amm_addr), .amm_writedata(wdata), .amm_readdata(rdata),
      .amm_read(rd), .amm_write(wr), .amm_byteenable(be), .amm_burstcount(bc),
      .amm_readdatavalid(rdv), .amm_ready(ready),
      .busy(busy), .setup_done(done), .setup_error(err), .err_count(errcnt)
   );

   ddr_region_init #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .NUM_WORDS(NW), .BASE_ADDR(0),
      .CONST_PAT(CPAT), .VERIFY(0), .AUTO_START(0)
   ) dut_nv (
      .clk(clk), .reset(nv_reset), .start(nv_start), .mode(nv_mode),
      .local_cal_success(nv_cal_ok), .local_cal_fail(nv_cal_fail),
      .amm_addr(nv_addr), .amm_writedata(nv_wdata), .amm_readdata(nv_rdata),
      .amm_read(nv_rd), .amm_write(nv_wr), .amm_byteenable(nv_be), .amm_burstcount(nv_bc),
      .amm_readdatavalid(nv_rdv), .amm_ready(nv_ready),
      .busy(nv_busy), .setup_done(nv_done), .setup_error(nv_err), .err_count(nv_errcnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   beat_t wq[$];
   beat_t nq[$];
   int    wr_seen = 0;
   int    nv_seen = 0;
   int    nv_rd_seen = 0;
   int    rd_cmds = 0;
   logic  toggle = 1'b0;
   logic  corrupt = 1'b0;

   logic [DW-1:0] mem [0:7];
   logic [2:0]    pend[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Hand-derived lane values: 0, i, CONST_PAT, ~i.
   function automatic logic [DW-1:0] pat(input int m, input int i);
      logic [31:0] lane;
      case (m)
         0:       lane = 32'h0;
         1:       lane = 32'(i);
         2:       lane = CPAT;
         default: lane = ~32'(i);
      endcase
      return {lane, lane};
   endfunction

   task automatic push_main(input int m, input int count);
      for (int k = 0; k < count; k++)
         wq.push_back('{addr: AW'((k / BL) * BL), data: pat(m, k)});
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_addr"},   64'(amm_addr), 64'h0);
      check({tag, "_wdata"},  wdata, 64'h0);
      check({tag, "_read"},   64'(rd), 64'h0);
      check({tag, "_write"},  64'(wr), 64'h0);
      check({tag, "_be"},     64'(be), 64'hFF);
      check({tag, "_bc"},     64'(bc), 64'd4);
      check({tag, "_busy"},   64'(busy), 64'h0);
      check({tag, "_done"},   64'(done), 64'h0);
      check({tag, "_error"},  64'(err), 64'h0);
      check({tag, "_errcnt"}, 64'(errcnt), 64'h0);
   endtask

   task automatic pulse_start(input logic [1:0] m);
      @(posedge clk); #1 start = 1'b1; mode = m;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({name, "_timeout_busy"}, 64'(busy), 64'h0);
   endtask

   // Scoreboard monitor, main DUT: pops one expectation per accepted write beat.
   initial begin : mon_main
      beat_t e;
      forever begin
         @(negedge clk);
         check("rd_wr_exclusive", 64'(rd & wr), 64'h0);
         if (!reset && wr) begin
            if (ready) begin
               wr_seen++;
               if (wq.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL wr_unexpected: got beat addr %h data %h, expected none", amm_addr, wdata);
               end else begin
                  e = wq.pop_front();
                  check("wr_addr", 64'(amm_addr), 64'(e.addr));
                  check("wr_data", wdata, e.data);
               end
            end else if (wq.size() != 0) begin
               check("stall_addr", 64'(amm_addr), 64'(wq[0].addr));
            end
         end
      end
   end

   // Scoreboard monitor, write-only DUT.
   initial begin : mon_nv
      beat_t e;
      forever begin
         @(negedge clk);
         if (nv_rd) nv_rd_seen++;
         if (!nv_reset && nv_wr && nv_ready) begin
            nv_seen++;
            if (nq.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL nv_wr_unexpected: got beat addr %h data %h, expected none", nv_addr, nv_wdata);
            end else begin
               e = nq.pop_front();
               check("nv_wr_addr", 64'(nv_addr), 64'(e.addr));
               check("nv_wr_data", nv_wdata, e.data);
            end
         end
      end
   end

   // Avalon slave model for the main DUT: memory plus one-burst read return.
   initial begin : slave
      int          wr_pos;
      logic [2:0]  a;
      wr_pos = 0;
      ready  = 1'b1;
      rdv    = 1'b0;
      rdata  = '0;
      for (int k = 0; k < 8; k++) mem[k] = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (!busy) wr_pos = 0;
            if (wr && ready) begin
               a = amm_addr[2:0] + 3'(wr_pos);
               mem[a] = wdata;
               wr_pos = (wr_pos + 1) % BL;
            end
            if (rd && ready) begin
               rd_cmds++;
               for (int b = 0; b < BL; b++) pend.push_back(amm_addr[2:0] + 3'(b));
            end
         end
         @(posedge clk);
         #2;
         if (reset) begin
            pend.delete();
            rdv    = 1'b0;
            wr_pos = 0;
            ready  = 1'b1;
         end else begin
            if (pend.size() > 0) begin
               a     = pend.pop_front();
               rdv   = 1'b1;
               rdata = mem[a] ^ ((corrupt && a == 3'd5) ? 64'h1 : 64'h0);
            end else begin
               rdv   = 1'b0;
               rdata = '0;
            end
            ready = toggle ? ~ready : 1'b1;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;
      int base;
      reset = 1'b1; start = 1'b0; mode = 2'd0; cal_ok = 1'b0; cal_fail = 1'b0;
      nv_reset = 1'b1; nv_start = 1'b0; nv_mode = 2'd0; nv_cal_ok = 1'b0; nv_cal_fail = 1'b0;
      nv_rdv = 1'b0; nv_ready = 1'b1; nv_rdata = '0;

      // ---- reset values, then auto start with mode 0
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("rst");
      push_main(0, NW);
      @(posedge clk); #1 reset = 1'b0; nv_reset = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk);
      check("A_waitcal_busy", 64'(busy), 64'h1);
      check("A_waitcal_nowrite", 64'(wr), 64'h0);
      @(posedge clk); #1 cal_ok = 1'b1;
      wait_idle("A", 400);
      check("A_done", 64'(done), 64'h1);
      check("A_error", 64'(err), 64'h0);
      check("A_errcnt", 64'(errcnt), 64'h0);
      check("A_queue_empty", 64'(wq.size()), 64'h0);
      check("A_read_cmds", 64'(rd_cmds), 64'd2);

      // ---- mode 1 with ready toggling
      toggle = 1'b1;
      push_main(1, NW);
      pulse_start(2'd1);
      @(negedge clk);
      check("B_done_cleared", 64'(done), 64'h0);
      wait_idle("B", 600);
      check("B_done", 64'(done), 64'h1);
      check("B_error", 64'(err), 64'h0);
      check("B_errcnt", 64'(errcnt), 64'h0);
      check("B_queue_empty", 64'(wq.size()), 64'h0);
      toggle = 1'b0;
      repeat (2) @(posedge clk);

      // ---- readback of word 5 corrupted
      corrupt = 1'b1;
      push_main(1, NW);
      pulse_start(2'd1);
      wait_idle("C", 400);
      check("C_errcnt", 64'(errcnt), 64'd1);
      check("C_done", 64'(done), 64'h1);
      check("C_error", 64'(err), 64'h1);
      check("C_queue_empty", 64'(wq.size()), 64'h0);
      corrupt = 1'b0;

      // ---- calibration failure on the 3rd write beat
      push_main(0, 3);
      base = wr_seen;
      pulse_start(2'd0);
      k = 0;
      do begin
         @(posedge clk); #1;
         k++;
      end while (!(wr && (wr_seen - base) == 2) && k < 100);
      check("D_reach_beat3_timeout", 64'(k < 100), 64'h1);
      cal_fail = 1'b1;
      @(posedge clk); #1;
      check("D_write_dropped", 64'(wr), 64'h0);
      check("D_busy", 64'(busy), 64'h0);
      cal_fail = 1'b0;
      @(negedge clk);
      check("D_error", 64'(err), 64'h1);
      check("D_done", 64'(done), 64'h0);
      check("D_queue_empty", 64'(wq.size()), 64'h0);

      // ---- reset during READ_DATA, auto restart with mode 0
      push_main(3, NW);
      pulse_start(2'd3);
      k = 0;
      do begin
         @(posedge clk); #3;
         k++;
      end while (!rdv && k < 200);
      check("E_reach_read_timeout", 64'(k < 200), 64'h1);
      check("E_writes_done", 64'(wq.size()), 64'h0);
      reset = 1'b1;
      push_main(0, NW);
      @(posedge clk); #1;
      @(negedge clk);
      check_reset_vals("E_rst");
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      wait_idle("E", 400);
      check("E_done", 64'(done), 64'h1);
      check("E_error", 64'(err), 64'h0);
      check("E_errcnt", 64'(errcnt), 64'h0);
      check("E_queue_empty", 64'(wq.size()), 64'h0);

      // ---- write-only instance, mode 2
      nv_cal_ok = 1'b1;
      for (int j = 0; j < NW; j++)
         nq.push_back('{addr: AW'((j / BL) * BL), data: pat(2, j)});
      @(posedge clk); #1 nv_start = 1'b1; nv_mode = 2'd2;
      @(posedge clk); #1 nv_start = 1'b0;
      k = 0;
      do begin
         @(negedge clk); #1;
         k++;
      end while (nv_seen != NW && k < 200);
      check("F_beats_timeout", 64'(nv_seen), 64'(NW));
      check("F_done_not_yet", 64'(nv_done), 64'h0);
      @(negedge clk);
      check("F_done_next_cycle", 64'(nv_done), 64'h1);
      check("F_error", 64'(nv_err), 64'h0);
      check("F_busy", 64'(nv_busy), 64'h0);
      check("F_queue_empty", 64'(nq.size()), 64'h0);
      check("F_no_reads", 64'(nv_rd_seen), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
